debug_response_tx: RTL

Serializes one debugger read response into a byte stream for the host link. It sits between the debugger command decoder, which supplies a 32-bit `result`, the 2-bit `size` field, and the originating command byte, and the UART transmitter byte port. Each accepted command produces an optional echo header, then `size+1` result bytes sent LSB first, then an optional XOR checksum byte. A valid/ready handshake is used on both sides.

---
 rtl/debug_pkg.sv | 22 ++
 rtl/debug_response_tx.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/debug_pkg.sv
// debug_pkg
// Shared definitions for the debugger response path: the response
// transmitter state encoding, the position of the size field inside a
// debugger command byte, and the checksum seed value.
package debug_pkg;

  // Response transmitter frame phases
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_CSUM = 2'd3
  } dbg_state_e;

  // Bit positions of the 2-bit size field inside a command byte
  localparam int DBG_SIZE_MSB = 7;
  localparam int DBG_SIZE_LSB = 6;

  // Seed of the running XOR checksum at the start of every frame
  localparam logic [7:0] DBG_CSUM_INIT = 8'h00;

endpackage : debug_pkg

// File: rtl/debug_response_tx.sv
// debug_response_tx
// Turns one debugger read response into a byte frame for the host UART:
//   [echoed command byte] , size+1 result bytes LSB first , [XOR checksum]
// The header and checksum bytes are present when ECHO_CMD / CHECKSUM are 1.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   cmd_valid  decoder offers a command
//   cmd_ready  block is idle and takes the command this cycle
//   cmd_code   command byte (echoed as the header)
//   result     32-bit read value to return
//   size       number of result bytes minus one
//   tx_data    byte presented to the UART transmitter
//   tx_valid   tx_data is valid
//   tx_ready   transmitter takes the byte this cycle
//   busy       a frame is in progress
module debug_response_tx
  import debug_pkg::*;
#(
  parameter bit ECHO_CMD = 1'b1,
  parameter bit CHECKSUM = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_code,
  input  logic [31:0] result,
  input  logic [1:0]  size,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy
);

  dbg_state_e  state_q,  state_d;
  logic [7:0]  code_q,   code_d;
  logic [31:0] result_q, result_d;
  logic [1:0]  size_q,   size_d;
  logic [1:0]  idx_q,    idx_d;
  logic [7:0]  acc_q,    acc_d;
  logic [7:0]  data_byte;

  // Result byte selected by the current data index, least significant first
  always_comb begin
    data_byte = 8'h00;
    case (idx_q)
      2'd0:    data_byte = result_q[7:0];
      2'd1:    data_byte = result_q[15:8];
      2'd2:    data_byte = result_q[23:16];
      default: data_byte = result_q[31:24];
    endcase
  end

  // Next-state and output logic. The captured command, size and result
  // only change in IDLE, so the presented byte stays stable while the
  // transmitter stalls, and commands arriving mid-frame are ignored.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    result_d  = result_q;
    size_d    = size_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    cmd_ready = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          code_d   = cmd_code;
          result_d = result;
          size_d   = size;
          idx_d    = 2'd0;
          acc_d    = DBG_CSUM_INIT;
          state_d  = ECHO_CMD ? ST_HDR : ST_DATA;
        end
      end

      ST_HDR: begin
        tx_valid = 1'b1;
        tx_data  = code_q;
        if (tx_ready) begin
          acc_d   = acc_q ^ code_q;
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        tx_valid = 1'b1;
        tx_data  = data_byte;
        if (tx_ready) begin
          acc_d = acc_q ^ data_byte;
          // The last data byte is the one whose index equals the size field
          if (idx_q == size_q) begin
            state_d = CHECKSUM ? ST_CSUM : ST_IDLE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end

      ST_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = acc_q;
        if (tx_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q != ST_IDLE);

  // State and frame registers. Reset abandons any frame in flight; a
  // transfer coinciding with reset is dropped along with it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      code_q   <= 8'h00;
      result_q <= 32'h0000_0000;
      size_q   <= 2'd0;
      idx_q    <= 2'd0;
      acc_q    <= DBG_CSUM_INIT;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      result_q <= result_d;
      size_q   <= size_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
    end
  end

endmodule : debug_response_tx
